// File: rtl/priority_encoder_pkg.sv
// ----------------------------------------------------------------------------
// priority_encoder_pkg
// Shared definitions for the registered priority encoder.
//   - DEFAULT_M / DEFAULT_N : default request width and index width
//   - clog2()               : ceiling log2, used to check that the index
//                             width can represent every request position
// ----------------------------------------------------------------------------
package priority_encoder_pkg;

    localparam int DEFAULT_M = 8;
    localparam int DEFAULT_N = 3;

    // Smallest w such that 2**w >= value. clog2(1) = 0.
    function automatic int clog2(input int value);
        int width;
        int span;
        width = 0;
        span  = 1;
        while (span < value) begin
            span  = span << 1;
            width = width + 1;
        end
        return width;
    endfunction

endpackage : priority_encoder_pkg

// File: rtl/priority_encoder_if.sv
// ----------------------------------------------------------------------------
// priority_encoder_if
// Signal bundle between a requester and the registered priority encoder.
//   en    : capture enable (requester -> encoder)
//   in    : m-bit request vector (requester -> encoder)
//   out   : registered index of the highest set request (encoder -> requester)
//   valid : registered "at least one request was set" (encoder -> requester)
// Modports:
//   master : requester side
//   slave  : encoder side
// ----------------------------------------------------------------------------
interface priority_encoder_if #(
    parameter int m = priority_encoder_pkg::DEFAULT_M,
    parameter int n = priority_encoder_pkg::DEFAULT_N
) ();

    logic         en;
    logic [m-1:0] in;
    logic [n-1:0] out;
    logic         valid;

    modport master (
        output en,
        output in,
        input  out,
        input  valid
    );

    modport slave (
        input  en,
        input  in,
        output out,
        output valid
    );

endinterface : priority_encoder_if

// File: rtl/priority_encoder_core.sv
// ----------------------------------------------------------------------------
// priority_encoder_core
// Purely combinational m-to-n priority encoder; the highest set index wins.
//   in  [m-1:0] : request vector
//   idx [n-1:0] : index of the highest set bit (0 when no bit is set)
//   any         : 1 when at least one bit of in is set
// ----------------------------------------------------------------------------
module priority_encoder_core
    import priority_encoder_pkg::*;
#(
    parameter int m = DEFAULT_M,
    parameter int n = DEFAULT_N
) (
    input  logic [m-1:0] in,
    output logic [n-1:0] idx,
    output logic         any
);

    // Ascending scan where later hits overwrite earlier ones, so the last
    // (highest) set position is what remains. The index is narrowed to n
    // bits; the top level guarantees 2**n >= m so nothing is lost, and
    // positions >= m are never visited, so unused codes cannot appear.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < m; i++) begin
            if (in[i]) begin
                idx = i[n-1:0];
                any = 1'b1;
            end
        end
    end

endmodule : priority_encoder_core

// File: rtl/priority_encoder.sv
// ----------------------------------------------------------------------------
// priority_encoder
// Registered m-to-n priority encoder. On each rising clk edge with en high,
// captures the index of the highest set bit of in and whether any bit was
// set. With en low the registers hold. Latency is exactly one cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears out and valid at once)
//   bus   : priority_encoder_if.slave (en, in -> out, valid)
// Parameters:
//   m : request width (m >= 2)
//   n : index width (2**n >= m), checked at elaboration
// ----------------------------------------------------------------------------
module priority_encoder
    import priority_encoder_pkg::*;
#(
    parameter int m = DEFAULT_M,
    parameter int n = DEFAULT_N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    priority_encoder_if.slave    bus
);

    // An index width that cannot name every request would silently alias
    // high requests onto low codes, so refuse to build it.
    if (m < 2) begin : g_bad_m
        $fatal(1, "priority_encoder: m=%0d must be >= 2", m);
    end
    if (n < clog2(m)) begin : g_bad_n
        $fatal(1, "priority_encoder: n=%0d too narrow for m=%0d (need %0d)",
               n, m, clog2(m));
    end

    logic [n-1:0] enc_idx;
    logic         enc_any;

    logic [n-1:0] out_d;
    logic [n-1:0] out_q;
    logic         valid_d;
    logic         valid_q;

    priority_encoder_core #(
        .m (m),
        .n (n)
    ) u_core (
        .in  (bus.in),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        if (bus.en) begin
            out_d   = enc_idx;
            valid_d = enc_any;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;

endmodule : priority_encoder

// File: tb/tb_priority_encoder.sv
module tb_priority_encoder;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    priority_encoder_if #(.m(8), .n(3)) bus8 ();
    priority_encoder_if #(.m(5), .n(3)) bus5 ();

    priority_encoder #(.m(8), .n(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    priority_encoder #(.m(5), .n(3)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] in;
        logic [2:0] exp_out;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic [7:0] in,
                                input logic [2:0] o, input logic v);
        vec_t r;
        r.en = en; r.in = in; r.exp_out = o; r.exp_valid = v;
        return r;
    endfunction

    // Drive on the falling edge, let one rising edge capture, check on the
    // following falling edge.
    task automatic apply8(input logic en, input logic [7:0] in);
        bus8.en = en;
        bus8.in = in;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply5(input logic en, input logic [4:0] in);
        bus5.en = en;
        bus5.in = in;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus8.en = 1'b0;
        bus8.in = '0;
        bus5.en = 1'b0;
        bus5.in = '0;

        for (int k = 0; k < 8; k++) vecs.push_back(mk(1'b1, 8'(1 << k), 3'(k), 1'b1));
        vecs.push_back(mk(1'b1, 8'b0000_1101, 3'd3, 1'b1));
        vecs.push_back(mk(1'b1, 8'b1111_1111, 3'd7, 1'b1));
        vecs.push_back(mk(1'b1, 8'b1000_0001, 3'd7, 1'b1));
        vecs.push_back(mk(1'b1, 8'h00,        3'd0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h01,        3'd0, 1'b1));
        vecs.push_back(mk(1'b1, 8'h40,        3'd6, 1'b1));
        vecs.push_back(mk(1'b0, 8'h02,        3'd6, 1'b1));
        vecs.push_back(mk(1'b0, 8'h02,        3'd6, 1'b1));
        vecs.push_back(mk(1'b0, 8'h02,        3'd6, 1'b1));
        vecs.push_back(mk(1'b1, 8'h02,        3'd1, 1'b1));
        vecs.push_back(mk(1'b1, 8'h00,        3'd0, 1'b0));
        vecs.push_back(mk(1'b0, 8'hff,        3'd0, 1'b0));

        // Reset state, with clock running and en high (must not capture).
        bus8.en = 1'b1;
        bus8.in = 8'hff;
        repeat (2) @(negedge clk);
        check("reset_out", int'(bus8.out), 0);
        check("reset_valid", int'(bus8.valid), 0);
        rst_n = 1'b1;
        bus8.en = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            apply8(vecs[i].en, vecs[i].in);
            check($sformatf("vec%0d_out", i), int'(bus8.out), int'(vecs[i].exp_out));
            check($sformatf("vec%0d_valid", i), int'(bus8.valid), int'(vecs[i].exp_valid));
        end

        // Asynchronous reset mid-cycle with out=5, valid=1.
        apply8(1'b1, 8'h20);
        check("pre_rst_out", int'(bus8.out), 5);
        check("pre_rst_valid", int'(bus8.valid), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", int'(bus8.out), 0);
        check("async_rst_valid", int'(bus8.valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        // First capture after release behaves as from power-up.
        apply8(1'b0, 8'h80);
        check("post_rst_hold_out", int'(bus8.out), 0);
        check("post_rst_hold_valid", int'(bus8.valid), 0);
        apply8(1'b1, 8'h10);
        check("post_rst_cap_out", int'(bus8.out), 4);
        check("post_rst_cap_valid", int'(bus8.valid), 1);

        // Back-to-back captures: each cycle reflects exactly the prior edge.
        bus8.en = 1'b1;
        bus8.in = 8'h04;
        @(posedge clk);
        #1 bus8.in = 8'h30;
        check("b2b_first_out", int'(bus8.out), 2);
        @(posedge clk);
        #1;
        check("b2b_second_out", int'(bus8.out), 5);
        @(negedge clk);

        // m=5 variant.
        apply5(1'b1, 5'b10010);
        check("m5_out", int'(bus5.out), 4);
        check("m5_valid", int'(bus5.valid), 1);
        apply5(1'b1, 5'b00000);
        check("m5_zero_out", int'(bus5.out), 0);
        check("m5_zero_valid", int'(bus5.valid), 0);
        apply5(1'b1, 5'b00001);
        check("m5_bit0_out", int'(bus5.out), 0);
        check("m5_bit0_valid", int'(bus5.valid), 1);
        apply5(1'b1, 5'b01011);
        check("m5_multi_out", int'(bus5.out), 3);
        apply5(1'b0, 5'b10000);
        check("m5_hold_out", int'(bus5.out), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_priority_encoder
